// File: rtl/video_timing_pkg.sv
// Shared types for the video timing generator/detector pair.
// FSM encoding, default counter width and the geometry tuple.
package video_timing_pkg;

  localparam int CNT_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TRACK,
    LOCKED
  } state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] htotal;
    logic [CNT_W_DEF-1:0] hactive;
    logic [CNT_W_DEF-1:0] vtotal;
    logic [CNT_W_DEF-1:0] vactive;
  } geom_t;

endpackage

// File: rtl/video_timing_detect_sync_edge_det.sv
// Input register plus rising-edge pulse on the registered copy.
// Used for hsync and vsync.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic q;
  logic q_d;

  // register the input and keep one cycle of history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= din;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;

endmodule

// File: rtl/video_timing_detect.sv
// Measures frame geometry of an hsync/vsync/active stream and locks.
// Optional err_count output: VIDEO_TIMING_DETECT_ERRCNT_EN.
module video_timing_detect
  import video_timing_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             video_hsync,
  input  logic             video_vsync,
  input  logic             active_video,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             frame_err,
  output logic             pixel_valid,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos
`ifdef VIDEO_TIMING_DETECT_ERRCNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [4:0]       LOCK_N = 5'(LOCK_FRAMES);

  logic hs_rise, vs_rise, act_q;

  sync_edge_det u_hs (
    .clk  (clk),
    .rst  (rst),
    .din  (video_hsync),
    .rise (hs_rise)
  );

  sync_edge_det u_vs (
    .clk  (clk),
    .rst  (rst),
    .din  (video_vsync),
    .rise (vs_rise)
  );

  logic [CNT_W-1:0] pix_cnt, act_cnt, line_cnt, act_line_cnt;
  logic [CNT_W-1:0] ref_ht, ref_ha;
  logic             ht_ok, ha_ok, frame_bad, ovf, line_open;

  logic [CNT_W-1:0] ref_ht_nx, ref_ha_nx, line_nx, aline_nx;
  logic             ht_ok_nx, ha_ok_nx, bad_nx, ovf_nx, same;

  state_t     state, state_nx;
  logic [3:0] match_cnt;
  logic       store, inc, err_nx, lock_nx;

  // line-end bookkeeping; frame end below sees the updated values
  always_comb begin
    ref_ht_nx = ref_ht;
    ref_ha_nx = ref_ha;
    ht_ok_nx  = ht_ok;
    ha_ok_nx  = ha_ok;
    bad_nx    = frame_bad;
    line_nx   = line_cnt;
    aline_nx  = act_line_cnt;
    ovf_nx    = ovf | (!hs_rise && pix_cnt == '1);
    if (hs_rise) begin
      line_nx = line_cnt + ONE;
      if (act_cnt != '0) aline_nx = act_line_cnt + ONE;
    end
    if (hs_rise && line_open) begin
      if (!ht_ok) begin
        ref_ht_nx = pix_cnt;
        ht_ok_nx  = 1'b1;
      end else if (pix_cnt != ref_ht) begin
        bad_nx = 1'b1;
      end
      if (act_cnt != '0) begin
        if (!ha_ok) begin
          ref_ha_nx = act_cnt;
          ha_ok_nx  = 1'b1;
        end else if (act_cnt != ref_ha) begin
          bad_nx = 1'b1;
        end
      end
    end
  end

  assign same = ({ref_ht_nx, ref_ha_nx, line_nx, aline_nx} ==
                 {h_total, h_active, v_total, v_active})
                && !bad_nx && !ovf_nx;

  // per-line and per-frame measurement counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q        <= 1'b0;
      pix_cnt      <= '0;
      act_cnt      <= '0;
      line_open    <= 1'b0;
      line_cnt     <= '0;
      act_line_cnt <= '0;
      ref_ht       <= '0;
      ref_ha       <= '0;
      ht_ok        <= 1'b0;
      ha_ok        <= 1'b0;
      frame_bad    <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      act_q <= active_video;
      if (hs_rise) begin
        pix_cnt   <= ONE;
        act_cnt   <= {{(CNT_W-1){1'b0}}, act_q};
        line_open <= 1'b1;
      end else begin
        if (pix_cnt != '1) pix_cnt <= pix_cnt + ONE;
        if (act_q && act_cnt != '1) act_cnt <= act_cnt + ONE;
      end
      if (vs_rise) begin
        line_cnt     <= '0;
        act_line_cnt <= '0;
        ref_ht       <= '0;
        ref_ha       <= '0;
        ht_ok        <= 1'b0;
        ha_ok        <= 1'b0;
        frame_bad    <= 1'b0;
        ovf          <= 1'b0;
      end else begin
        line_cnt     <= line_nx;
        act_line_cnt <= aline_nx;
        ref_ht       <= ref_ht_nx;
        ref_ha       <= ref_ha_nx;
        ht_ok        <= ht_ok_nx;
        ha_ok        <= ha_ok_nx;
        frame_bad    <= bad_nx;
        ovf          <= ovf_nx;
      end
    end
  end

  // lock FSM: next state and frame-end actions
  always_comb begin
    state_nx = state;
    store    = 1'b0;
    inc      = 1'b0;
    err_nx   = 1'b0;
    lock_nx  = locked;
    if (vs_rise) begin
      unique case (state)
        IDLE: state_nx = MEASURE;
        MEASURE: begin
          state_nx = TRACK;
          store    = 1'b1;
        end
        TRACK: begin
          if (same) begin
            inc = 1'b1;
            if ({1'b0, match_cnt} + 5'd1 >= LOCK_N) begin
              state_nx = LOCKED;
              lock_nx  = 1'b1;
            end
          end else begin
            store  = 1'b1;
            err_nx = 1'b1;
          end
        end
        LOCKED: begin
          if (!same) begin
            state_nx = TRACK;
            store    = 1'b1;
            err_nx   = 1'b1;
            lock_nx  = 1'b0;
          end
        end
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // stored geometry, match counter and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_total   <= '0;
      h_active  <= '0;
      v_total   <= '0;
      v_active  <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (store) begin
        h_total   <= ref_ht_nx;
        h_active  <= ref_ha_nx;
        v_total   <= line_nx;
        v_active  <= aline_nx;
        match_cnt <= 4'd1;
      end else if (inc) begin
        match_cnt <= match_cnt + 4'd1;
      end
      locked    <= lock_nx;
      frame_err <= err_nx;
    end
  end

  // pixel coordinates, one register after the input stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
    end else begin
      pixel_valid <= act_q & locked;
      if (act_q && locked) begin
        x_pos <= hs_rise ? '0 : act_cnt;
        y_pos <= vs_rise ? '0 : aline_nx;
      end
    end
  end

`ifdef VIDEO_TIMING_DETECT_ERRCNT_EN
  // saturating count of frame_err pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count <= '0;
    else if (err_nx && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_video_timing_detect.sv
// Directed bench for video_timing_detect.
// 16x8 active in a 24x12 raster, lock/err/ovf/reset scenarios.
module tb_video_timing_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic        video_hsync, video_vsync, active_video;
  logic [11:0] h_total, h_active, v_total, v_active;
  logic        locked, frame_err, pixel_valid;
  logic [11:0] x_pos, y_pos;
`ifdef VIDEO_TIMING_DETECT_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int err_pulses = 0;

  logic        snap_locked, snap_err;
  logic [11:0] snap_ht, snap_ha, snap_vt, snap_va;
  bit          pix_chk = 0;
  logic [11:0] exp_x, exp_y;

  video_timing_detect #(.CNT_W(12), .LOCK_FRAMES(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .video_hsync  (video_hsync),
    .video_vsync  (video_vsync),
    .active_video (active_video),
    .h_total      (h_total),
    .h_active     (h_active),
    .v_total      (v_total),
    .v_active     (v_active),
    .locked       (locked),
    .frame_err    (frame_err),
    .pixel_valid  (pixel_valid),
    .x_pos        (x_pos),
    .y_pos        (y_pos)
`ifdef VIDEO_TIMING_DETECT_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic idle(input int n);
    video_hsync  = 1'b0;
    video_vsync  = 1'b0;
    active_video = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // raster lines first..last; bad_line is one clock longer
  task automatic gen_lines(input int first, input int last,
                           input int bad_line);
    int len;
    bit prev_act;
    int prev_l, prev_p;
    prev_act = 0;
    prev_l   = 0;
    prev_p   = 0;
    for (int l = first; l <= last; l++) begin
      len = (l == bad_line) ? 25 : 24;
      for (int p = 0; p < len; p++) begin
        video_hsync  = (p < 2);
        video_vsync  = (l < 2);
        active_video = (l >= 2 && l < 10 && p >= 4 && p < 20);
        @(posedge clk); #1;
        if (l == 0 && p == 1) begin
          snap_locked = locked;
          snap_err    = frame_err;
          snap_ht     = h_total;
          snap_ha     = h_active;
          snap_vt     = v_total;
          snap_va     = v_active;
        end
        if (pix_chk) begin
          if (prev_act) begin
            exp_x = 12'(prev_p - 4);
            exp_y = 12'(prev_l - 2);
          end
          chk_cnt++;
          if (pixel_valid !== prev_act)
            $display("FAIL pix_valid l%0d p%0d: got %b want %b",
                     l, p, pixel_valid, prev_act);
          else pass_cnt++;
          chk_cnt++;
          if (x_pos !== exp_x || y_pos !== exp_y)
            $display("FAIL pix_xy l%0d p%0d: got %0d,%0d want %0d,%0d",
                     l, p, x_pos, y_pos, exp_x, exp_y);
          else pass_cnt++;
        end
        prev_act = active_video;
        prev_l   = l;
        prev_p   = p;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    chk_cnt++;
    if ({h_total, h_active, v_total, v_active} !== 48'h0)
      $display("FAIL rst_geom: got %h want 0",
               {h_total, h_active, v_total, v_active});
    else pass_cnt++;
    chk_cnt++;
    if ({locked, frame_err, pixel_valid} !== 3'b000)
      $display("FAIL rst_flags: got %b want 000",
               {locked, frame_err, pixel_valid});
    else pass_cnt++;
    chk_cnt++;
    if ({x_pos, y_pos} !== 24'h0)
      $display("FAIL rst_xy: got %h want 0", {x_pos, y_pos});
    else pass_cnt++;
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_lock;
    int base;
    base = err_pulses;
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_locked !== 1'b0 || snap_ht !== 12'd0)
      $display("FAIL lock_f1: locked=%b ht=%0d want 0,0",
               snap_locked, snap_ht);
    else pass_cnt++;
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_locked !== 1'b0 || snap_ht !== 12'd24)
      $display("FAIL lock_f2: locked=%b ht=%0d want 0,24",
               snap_locked, snap_ht);
    else pass_cnt++;
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_locked !== 1'b0)
      $display("FAIL lock_f3: locked=%b want 0", snap_locked);
    else pass_cnt++;
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_locked !== 1'b1)
      $display("FAIL lock_f4: locked=%b want 1", snap_locked);
    else pass_cnt++;
    chk_cnt++;
    if ({snap_ht, snap_ha, snap_vt, snap_va} !==
        {12'd24, 12'd16, 12'd12, 12'd8})
      $display("FAIL geom: got %0d %0d %0d %0d want 24 16 12 8",
               snap_ht, snap_ha, snap_vt, snap_va);
    else pass_cnt++;
    chk_cnt++;
    if (err_pulses - base !== 0)
      $display("FAIL lock_noerr: got %0d pulses want 0",
               err_pulses - base);
    else pass_cnt++;
  endtask

  task automatic test_frame_err;
    int base;
    gen_lines(0, 11, 5);
    base = err_pulses;
    chk_cnt++;
    if (snap_locked !== 1'b1)
      $display("FAIL err_pre: locked=%b want 1", snap_locked);
    else pass_cnt++;
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_err !== 1'b1 || snap_locked !== 1'b0)
      $display("FAIL err_pulse: err=%b locked=%b want 1,0",
               snap_err, snap_locked);
    else pass_cnt++;
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_err !== 1'b0 || snap_locked !== 1'b0)
      $display("FAIL err_track: err=%b locked=%b want 0,0",
               snap_err, snap_locked);
    else pass_cnt++;
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_locked !== 1'b1 || snap_ht !== 12'd24)
      $display("FAIL err_relock: locked=%b ht=%0d want 1,24",
               snap_locked, snap_ht);
    else pass_cnt++;
    chk_cnt++;
    if (err_pulses - base !== 1)
      $display("FAIL err_count1: got %0d pulses want 1",
               err_pulses - base);
    else pass_cnt++;
  endtask

  task automatic test_coords;
    exp_x   = 12'd15;
    exp_y   = 12'd7;
    pix_chk = 1;
    gen_lines(0, 11, -1);
    gen_lines(0, 11, -1);
    pix_chk = 0;
  endtask

  task automatic test_ovf;
    for (int i = 0; i < 5002; i++) begin
      video_hsync  = (i < 2);
      video_vsync  = (i < 2);
      active_video = 1'b0;
      @(posedge clk); #1;
      if (i == 1) begin
        chk_cnt++;
        if (locked !== 1'b1 || frame_err !== 1'b0)
          $display("FAIL ovf_pre: locked=%b err=%b want 1,0",
                   locked, frame_err);
        else pass_cnt++;
      end
    end
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_err !== 1'b1 || snap_locked !== 1'b0)
      $display("FAIL ovf_err: err=%b locked=%b want 1,0",
               snap_err, snap_locked);
    else pass_cnt++;
    gen_lines(0, 11, -1);
    gen_lines(0, 11, -1);
  endtask

  task automatic test_reset_mid;
    gen_lines(0, 4, -1);
    chk_cnt++;
    if (snap_locked !== 1'b1)
      $display("FAIL mid_pre: locked=%b want 1", snap_locked);
    else pass_cnt++;
    #3 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({h_total, h_active, v_total, v_active} !== 48'h0 ||
        {locked, frame_err, pixel_valid} !== 3'b000 ||
        {x_pos, y_pos} !== 24'h0)
      $display("FAIL mid_rst: geom=%h flags=%b xy=%h want 0",
               {h_total, h_active, v_total, v_active},
               {locked, frame_err, pixel_valid}, {x_pos, y_pos});
    else pass_cnt++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    gen_lines(5, 11, -1);
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_locked !== 1'b0 || snap_ht !== 12'd0)
      $display("FAIL mid_f1: locked=%b ht=%0d want 0,0",
               snap_locked, snap_ht);
    else pass_cnt++;
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_ht !== 12'd24 || snap_locked !== 1'b0)
      $display("FAIL mid_f2: locked=%b ht=%0d want 0,24",
               snap_locked, snap_ht);
    else pass_cnt++;
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_locked !== 1'b0)
      $display("FAIL mid_f3: locked=%b want 0", snap_locked);
    else pass_cnt++;
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (snap_locked !== 1'b1)
      $display("FAIL mid_f4: locked=%b want 1", snap_locked);
    else pass_cnt++;
  endtask

`ifdef VIDEO_TIMING_DETECT_ERRCNT_EN
  task automatic test_errcnt;
    rst = 1'b1;
    idle(2);
    chk_cnt++;
    if (err_count !== 16'd0)
      $display("FAIL errcnt_rst: got %0d want 0", err_count);
    else pass_cnt++;
    rst = 1'b0;
    idle(3);
    gen_lines(0, 11, -1);
    gen_lines(0, 11, 5);
    gen_lines(0, 11, 5);
    gen_lines(0, 11, 5);
    gen_lines(0, 11, -1);
    chk_cnt++;
    if (err_count !== 16'd3)
      $display("FAIL errcnt: got %0d want 3", err_count);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst          = 1'b1;
    video_hsync  = 1'b0;
    video_vsync  = 1'b0;
    active_video = 1'b0;
    test_reset;
    test_lock;
    test_frame_err;
    test_coords;
    test_ovf;
    test_reset_mid;
`ifdef VIDEO_TIMING_DETECT_ERRCNT_EN
    test_errcnt;
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
